// File: rtl/serial_pattern_tx.sv
// Parallel-to-serial frame transmitter: words arrive over valid/ready and leave
// MSB-first on sout, one bit per clock, with an optional idle gap between frames.
module serial_pattern_tx #(
  parameter int WIDTH = 5,
  parameter int GAP   = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAPS} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sh, w_sh_nxt;
  logic [BW-1:0]    r_bitcnt, w_bitcnt_nxt;
  logic [GW-1:0]    r_gapcnt, w_gapcnt_nxt;
  logic [CNT_W-1:0] r_frame_cnt, w_frame_cnt_nxt;
  logic             w_last;
  logic             w_accept;

  assign w_last   = (r_state == SHIFT) && (r_bitcnt == BIT_LAST);
  assign w_accept = in_valid & in_ready;

  // in_ready depends only on registered state, never on in_valid
  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      IDLE:    in_ready = 1'b1;
      SHIFT:   in_ready = w_last && (GAP == 0);
      GAPS:    in_ready = (r_gapcnt == GAP_LAST);
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_sh_nxt        = r_sh;
    w_bitcnt_nxt    = r_bitcnt;
    w_gapcnt_nxt    = r_gapcnt;
    w_frame_cnt_nxt = r_frame_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt  = SHIFT;
          w_sh_nxt     = in_data;
          w_bitcnt_nxt = '0;
        end
      end
      SHIFT: begin
        if (!w_last) begin
          w_sh_nxt     = r_sh << 1;
          w_bitcnt_nxt = r_bitcnt + BW'(1);
        end else begin
          w_frame_cnt_nxt = r_frame_cnt + CNT_W'(1);
          if (GAP > 0) begin
            w_state_nxt  = GAPS;
            w_gapcnt_nxt = '0;
          end else if (w_accept) begin
            // back-to-back reload keeps the line busy with no bubble
            w_sh_nxt     = in_data;
            w_bitcnt_nxt = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      GAPS: begin
        if (r_gapcnt != GAP_LAST) begin
          w_gapcnt_nxt = r_gapcnt + GW'(1);
        end else if (w_accept) begin
          w_state_nxt  = SHIFT;
          w_sh_nxt     = in_data;
          w_bitcnt_nxt = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sh        <= '0;
      r_bitcnt    <= '0;
      r_gapcnt    <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sh        <= w_sh_nxt;
      r_bitcnt    <= w_bitcnt_nxt;
      r_gapcnt    <= w_gapcnt_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
    end
  end

  assign sout_valid = (r_state == SHIFT);
  assign sout       = (r_state == SHIFT) & r_sh[WIDTH-1];
  assign last       = w_last;
  assign busy       = (r_state != IDLE);
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: two instances (GAP=0/CNT_W=2 and
// GAP=2/CNT_W=8) checked against a frame-timeline reference model.
module tb_serial_pattern_tx;
  localparam int W  = 5;
  localparam int G0 = 0;
  localparam int G1 = 2;

  typedef struct {
    logic b;
    logic l;
    int   cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       vld [2];
  logic [W-1:0] dat [2];
  logic       rdy [2];
  logic       so  [2];
  logic       sov [2];
  logic       lst [2];
  logic       bsy [2];
  logic [1:0] fc0;
  logic [7:0] fc1;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   last_t [2];
  int   cnt_exp [2];
  bit   mon_en = 1'b0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_pattern_tx #(.WIDTH(W), .GAP(G0), .CNT_W(2)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_data(dat[0]), .in_ready(rdy[0]),
    .sout(so[0]), .sout_valid(sov[0]), .last(lst[0]), .busy(bsy[0]), .frame_cnt(fc0)
  );

  serial_pattern_tx #(.WIDTH(W), .GAP(G1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_data(dat[1]), .in_ready(rdy[1]),
    .sout(so[1]), .sout_valid(sov[1]), .last(lst[1]), .busy(bsy[1]), .frame_cnt(fc1)
  );

  task automatic chk(input string nm, input int id, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s ch%0d cyc=%0d actual=%0d required=%0d", nm, id, cyc, act, exp);
    end
  endtask

  // Reference model: a frame accepted at cycle t owns cycles t+1..t+W for its bits,
  // the transmitter is ready again from cycle t+W+GAP and busy until then.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int   g;
      int   fcv;
      int   mask;
      bit   has;
      exp_t e;
      g    = (i == 0) ? G0 : G1;
      fcv  = (i == 0) ? int'(fc0) : int'(fc1);
      mask = (i == 0) ? 3 : 255;
      has  = 1'b0;
      if (i == 0 && q0.size() > 0 && q0[0].cyc == cyc) begin
        has = 1'b1;
        e   = q0.pop_front();
      end else if (i == 1 && q1.size() > 0 && q1[0].cyc == cyc) begin
        has = 1'b1;
        e   = q1.pop_front();
      end
      if (mon_en) begin
        chk("in_ready", i, rdy[i], cyc >= last_t[i] + W + g);
        chk("busy", i, bsy[i], (cyc > last_t[i]) && (cyc <= last_t[i] + W + g));
        chk("frame_cnt", i, fcv, cnt_exp[i] & mask);
        chk("sout_valid", i, sov[i], has);
        if (has && sov[i]) begin
          chk("sout_bit", i, so[i], e.b);
          chk("last", i, lst[i], e.l);
        end else if (!sov[i]) begin
          chk("sout_idle", i, so[i], 0);
          chk("last_idle", i, lst[i], 0);
        end
        if (has && e.l) cnt_exp[i]++;
      end
    end
    if (rst) begin
      mon_en = 1'b1;
      q0.delete();
      q1.delete();
      for (int i = 0; i < 2; i++) begin
        last_t[i]  = -100;
        cnt_exp[i] = 0;
      end
    end
  end

  task automatic push(input int id, input logic [W-1:0] d, input int t);
    for (int k = 0; k < W; k++) begin
      exp_t e;
      e.b   = d[W-1-k];
      e.l   = (k == W - 1);
      e.cyc = t + 1 + k;
      if (id == 0) q0.push_back(e);
      else         q1.push_back(e);
    end
  endtask

  // Presents d and waits for acceptance; in_valid stays high on return.
  task automatic send(input int id, input logic [W-1:0] d);
    bit ok;
    ok      = 1'b0;
    vld[id] = 1'b1;
    dat[id] = d;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      #1;
      if (rdy[id]) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept", id, ok, 1);
    if (ok) begin
      last_t[id] = cyc;
      push(id, d, cyc);
      @(posedge clk);
      #1;
      dat[id] = W'($urandom);
    end else begin
      vld[id] = 1'b0;
    end
  endtask

  task automatic stop(input int id);
    vld[id] = 1'b0;
    dat[id] = W'($urandom);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_ch(input int id);
    for (int f = 0; f < 25; f++) begin
      send(id, W'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        stop(id);
        cycles($urandom_range(0, 4));
      end
    end
    stop(id);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    vld[0] = 1'b0; vld[1] = 1'b0;
    dat[0] = '0;   dat[1] = '0;
    cycles(2);
    rst = 1'b0;
    chk("rst_in_ready", 0, rdy[0], 1);
    chk("rst_busy", 1, bsy[1], 0);
    chk("rst_frame_cnt", 0, fc0, 0);

    // single 10010 frame, no gap
    send(0, 5'b10010);
    stop(0);
    cycles(8);
    chk("single_frame_cnt", 0, fc0, 1);
    chk("single_idle", 0, bsy[0], 0);

    // back-to-back 10010, 01101 with in_valid held
    send(0, 5'b10010);
    send(0, 5'b01101);
    stop(0);
    cycles(8);
    chk("b2b_frame_cnt", 0, fc0, 3);

    // gap=2 instance, two frames back-to-back
    send(1, 5'b10010);
    send(1, 5'b01101);
    stop(1);
    cycles(12);
    chk("gap_frame_cnt", 1, fc1, 2);

    // reset after two bits of a frame
    send(0, 5'b10010);
    stop(0);
    cycles(1);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    chk("midrst_busy", 0, bsy[0], 0);
    chk("midrst_sout_valid", 0, sov[0], 0);
    chk("midrst_frame_cnt", 0, fc0, 0);
    cycles(8);

    // idle with changing data and in_valid low, then counter wrap
    for (int n = 0; n < 5; n++) begin
      dat[0] = W'($urandom);
      cycles(1);
    end
    chk("idle_stays", 0, bsy[0], 0);
    for (int n = 0; n < 5; n++) begin
      send(0, W'($urandom));
      stop(0);
      cycles($urandom_range(0, 3));
    end
    cycles(8);
    chk("wrap_frame_cnt", 0, fc0, 1);

    fork
      rand_ch(0);
      rand_ch(1);
    join

    for (int n = 0; n < 100; n++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      cycles(1);
    end
    chk("drain", 0, q0.size() + q1.size(), 0);
    cycles(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
